// File: rtl/game_pkg.sv
// Shared types and constants for the key judge stage: FSM states, direction
// encodings, LFSR taps and small bit-vector helpers.
package game_pkg;

    localparam int NUM_KEYS = 4;

    typedef enum logic [1:0] {
        WAIT_PRESS   = 2'd0,
        JUDGE        = 2'd1,
        WAIT_RELEASE = 2'd2,
        LOCK         = 2'd3
    } state_t;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    // Taps 8,6,5,4 of a left-shifting Fibonacci LFSR, feedback into bit 0
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_step(input logic [7:0] value);
        return {value[6:0], ^(value & LFSR_TAPS)};
    endfunction

    function automatic logic is_onehot(input logic [NUM_KEYS-1:0] value);
        return (value != {NUM_KEYS{1'b0}}) &&
               ((value & (value - {{(NUM_KEYS-1){1'b0}}, 1'b1})) == {NUM_KEYS{1'b0}});
    endfunction

    function automatic logic [NUM_KEYS-1:0] dir_mask(input logic [1:0] dir);
        return {{(NUM_KEYS-1){1'b0}}, 1'b1} << dir;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchronizer plus stability counter; `stable` only follows the
// synchronized vector after it has held for DEBOUNCE_CYCLES samples.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int WIDTH           = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] keys,
    output logic [WIDTH-1:0] stable,
    output logic             settled
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("key_debouncer: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] raw_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] stable_r;
    logic             settled_r;
    logic             load_s;

    // sync1_r is the sample raw_r takes next, so equality means raw holds another cycle
    always_comb begin
        load_s = 1'b0;
        if ((sync1_r == raw_r) && (cnt_r == CNT_LAST)) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
    end

    // Synchronizer, saturating stability counter and accepted-vector register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r   <= {WIDTH{1'b0}};
            raw_r     <= {WIDTH{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            stable_r  <= {WIDTH{1'b0}};
            settled_r <= 1'b0;
        end else begin
            sync1_r <= keys;
            raw_r   <= sync1_r;
            if (sync1_r != raw_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r != CNT_LAST) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
            if (load_s) begin
                stable_r  <= raw_r;
                settled_r <= 1'b1;
            end
        end
    end

    assign stable  = stable_r;
    assign settled = settled_r;

endmodule

// File: rtl/key_judge_player.sv
// Judges debounced player presses against the LFSR target direction and
// pulses correct/wrong. Optional penalty lockout under PENALTY_LOCK_EN.
module key_judge_player
    import game_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter logic [7:0] LFSR_SEED       = 8'hA5,
    parameter int         LOCK_CYCLES     = 25000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic                ended,
    output logic                correct,
    output logic                wrong,
    output logic [1:0]          target,
    output logic                locked
);

    localparam logic [7:0] SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    if (LOCK_CYCLES < 1) begin : g_bad_lock
        $error("key_judge_player: LOCK_CYCLES must be >= 1");
    end

    logic [NUM_KEYS-1:0] keys_s;
    logic [NUM_KEYS-1:0] stable_s;
    logic                settled_s;
    state_t              state_r;
    state_t              state_s;
    logic [7:0]          lfsr_r;
    logic                correct_r;
    logic                wrong_r;
    logic                hit_s;
    logic                correct_s;
    logic                wrong_s;

    assign keys_s = ~key_n;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .WIDTH          (NUM_KEYS)
    ) u_debouncer (
        .clk    (clk),
        .reset  (reset),
        .keys   (keys_s),
        .stable (stable_s),
        .settled(settled_s)
    );

`ifdef PENALTY_LOCK_EN
    localparam int                LOCK_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);

    logic [LOCK_W-1:0] lock_cnt_r;
    logic              locked_r;
    logic              lock_done_s;

    assign lock_done_s = (lock_cnt_r == {LOCK_W{1'b0}});

    // Lockout counter: loaded on a wrong judgment, counts down while in LOCK
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_cnt_r <= {LOCK_W{1'b0}};
            locked_r   <= 1'b0;
        end else begin
            if ((state_r == JUDGE) && wrong_s) begin
                lock_cnt_r <= LOCK_LOAD;
            end else if ((state_r == LOCK) && !lock_done_s) begin
                lock_cnt_r <= lock_cnt_r - LOCK_ONE;
            end
            locked_r <= (state_s == LOCK);
        end
    end

    assign locked = locked_r;
`else
    assign locked = 1'b0;
`endif

    // Judgment of the accepted vector; only meaningful during JUDGE
    always_comb begin
        hit_s     = 1'b0;
        correct_s = 1'b0;
        wrong_s   = 1'b0;
        hit_s     = is_onehot(stable_s) && (stable_s == dir_mask(lfsr_r[1:0]));
        if ((state_r == JUDGE) && !ended) begin
            correct_s = hit_s;
            wrong_s   = !hit_s;
        end else begin
            correct_s = 1'b0;
            wrong_s   = 1'b0;
        end
    end

    // Next-state logic; release is only trusted once the debouncer has sampled
    always_comb begin
        state_s = state_r;
        case (state_r)
            WAIT_PRESS: begin
                if (stable_s != {NUM_KEYS{1'b0}}) begin
                    state_s = JUDGE;
                end else begin
                    state_s = WAIT_PRESS;
                end
            end
            JUDGE: begin
`ifdef PENALTY_LOCK_EN
                if (wrong_s) begin
                    state_s = LOCK;
                end else begin
                    state_s = WAIT_RELEASE;
                end
`else
                state_s = WAIT_RELEASE;
`endif
            end
            WAIT_RELEASE: begin
                if (settled_s && (stable_s == {NUM_KEYS{1'b0}})) begin
                    state_s = WAIT_PRESS;
                end else begin
                    state_s = WAIT_RELEASE;
                end
            end
            LOCK: begin
`ifdef PENALTY_LOCK_EN
                if (ended || lock_done_s) begin
                    state_s = WAIT_RELEASE;
                end else begin
                    state_s = LOCK;
                end
`else
                state_s = WAIT_RELEASE;
`endif
            end
            default: begin
                state_s = WAIT_RELEASE;
            end
        endcase
    end

    // State register, registered pulses and pattern LFSR
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= WAIT_RELEASE;
            correct_r <= 1'b0;
            wrong_r   <= 1'b0;
            lfsr_r    <= SEED_EFF;
        end else begin
            state_r   <= state_s;
            correct_r <= correct_s;
            wrong_r   <= wrong_s;
            if (correct_s) begin
                lfsr_r <= lfsr_step(lfsr_r);
            end
        end
    end

    assign correct = correct_r;
    assign wrong   = wrong_r;
    assign target  = lfsr_r[1:0];

endmodule

// File: doc/key_judge_player.md
Name: key_judge_player

Overview:
Upstream stage of the player score countdown. Conditions the four raw player pushbuttons, holds the current target direction from an LFSR pattern, and judges each debounced press. Emits a one-cycle `correct` pulse that drives the countdown's decrement input, or a one-cycle `wrong` pulse. Takes the countdown's `ended` flag back so judging stops at game over.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive cycles the synchronized key vector must be unchanged before it is accepted (10 ms at 50 MHz); must be >= 1.
- LFSR_SEED, 8'hA5, reset value of the pattern LFSR; a value of 0 is replaced by 8'h01.
- LOCK_CYCLES, 25000000, penalty lockout length in cycles; used only with PENALTY_LOCK_EN.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- key_n  input  4  raw pushbuttons, active-low, asynchronous to clk; bit i = direction i (0 up, 1 down, 2 left, 3 right).
- ended  input  1  game-over flag from the score countdown; level-sensitive.
- correct  output  1  one-cycle pulse: the press matched the target.
- wrong  output  1  one-cycle pulse: the press did not match.
- target  output  2  current expected direction, equal to lfsr[1:0].
- locked  output  1  penalty lockout active; constant 0 without PENALTY_LOCK_EN.

Behaviour:
- Reset values: correct=0, wrong=0, locked=0, lfsr=LFSR_SEED (or 8'h01), target=lfsr[1:0], sync flops=0, stable vector=0, debounce counter=0, FSM=WAIT_RELEASE. Starting in WAIT_RELEASE means a key held through reset is never judged.
- Input path:
  - Invert key_n, then pass through a 2-flop synchronizer to give `raw`.
  - If `raw` differs from the last sample, clear the counter. Otherwise increment it, saturating.
  - When the counter reaches DEBOUNCE_CYCLES-1, load `stable` <= `raw`.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- FSM states and transitions:
  - WAIT_PRESS: go to JUDGE when stable != 0.
  - JUDGE: one cycle only, then go to WAIT_RELEASE (or LOCK, see Optional Feature).
  - WAIT_RELEASE: go to WAIT_PRESS when stable == 0.
- Judging, registered in JUDGE, so the pulse appears the cycle after JUDGE:
  - correct=1 iff stable is one-hot, stable == (1 << target), and ended==0. In the same edge the LFSR advances one step.
  - wrong=1 iff ended==0 and the press is not correct. Multi-key chords count as wrong.
  - correct and wrong are never high together. Each pulse lasts exactly one cycle per press.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4 (maximal length, 255 states). It advances only on a correct judgment and is never 0.
- ended=1:
  - No correct or wrong pulses.
  - LFSR frozen.
  - FSM keeps cycling normally, so releases are still tracked.
- Bounce shorter than DEBOUNCE_CYCLES: it never reaches `stable`, so no pulse.
- A second key added while one is held: no new judgment until all keys have been released.
- Reset mid-press: all state returns to reset values immediately and asynchronously. The still-held key is then ignored until released.

Optional Feature:
PENALTY_LOCK_EN.
- Defined:
  - A wrong judgment sends the FSM from JUDGE to LOCK and loads the lock counter with LOCK_CYCLES-1.
  - `locked` is 1 throughout LOCK; stable-vector changes are ignored.
  - When the counter reaches 0, go to WAIT_RELEASE and clear `locked`.
  - reset or ended=1 clears the lock at once.
- Undefined: no LOCK state and no lock counter; `locked` is tied to 0; a wrong judgment goes straight to WAIT_RELEASE.

Decomposition:
- Package game_pkg:
  - FSM state enum (WAIT_PRESS, JUDGE, WAIT_RELEASE, LOCK).
  - Direction encodings DIR_UP..DIR_RIGHT.
  - LFSR tap mask 8'hB8.
  - Key count constant NUM_KEYS=4.
- Sub-module key_debouncer: synchronizer, stability counter and `stable` register; parameterized by DEBOUNCE_CYCLES and width.
- The top level holds the FSM, LFSR, judge logic and lock logic.

Test Plan (DEBOUNCE_CYCLES=4, LOCK_CYCLES=8, LFSR_SEED=8'hA5):
1. Reset, then read target -> target=2'b01; no pulses for 20 cycles with all keys released.
2. Hold key_n=4'b1101 (down) for 10 cycles, then release -> exactly one correct pulse, 2+4+2 cycles after the press edge; LFSR advances once and target shows the new lfsr[1:0].
3. Hold a non-target key, and separately a two-key chord -> one wrong pulse each; LFSR and target unchanged.
4. Toggle a key every 2 cycles for 20 cycles, then release -> no pulses.
5. Set ended=1 and press the correct key -> no correct or wrong pulse, target unchanged. Clear ended and press again -> correct pulse.
6. With PENALTY_LOCK_EN defined: wrong press -> locked=1 for 8 cycles; a correct press inside the window gives no pulse. After release and a fresh correct press -> correct pulse.
